// File: rtl/usart_rx_oversampled_pkg.sv
// Shared USART receive definitions: FSM states, oversampling constants, parity helper.
package usart_rx_oversampled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BIT_IDX_W  = $clog2(DATA_W);

  // Tick positions within one bit period
  localparam int unsigned SAMPLE_T0 = 7;
  localparam int unsigned SAMPLE_T1 = 8;
  localparam int unsigned SAMPLE_T2 = 9;
  localparam int unsigned DECIDE_T  = 15;

  // Returns 1 when data plus parity bit hold an odd number of ones
  function automatic logic even_parity_checker(input logic [DATA_W:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/usart_rx_oversampled_rx_sampler.sv
// Line synchronizer and 2-of-3 mid-bit majority voter.
module usart_rx_oversampled_rx_sampler (
  input  logic CPU_Clk,
  input  logic Reset,
  input  logic RxBit,
  input  logic sample_en,
  input  logic vote_en,
  output logic rx_s,
  output logic vote_c,
  output logic voted
);

  logic       rx_meta;
  logic [1:0] smp;

  // Two-flop synchronizer, idles high
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxBit;
      rx_s    <= rx_meta;
    end
  end

  // Capture the first two mid-bit samples; the third is taken live at the vote tick
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      smp <= 2'b11;
    end else if (sample_en) begin
      smp <= {smp[0], rx_s};
    end
  end

  // Majority of the two stored samples and the current line value
  always_comb begin
    vote_c = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);
  end

  // Hold the decided bit until the end-of-bit tick consumes it
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      voted <= 1'b1;
    end else if (vote_en) begin
      voted <= vote_c;
    end
  end

endmodule

// File: rtl/usart_rx_oversampled.sv
// 16x oversampled asynchronous receiver with framing/parity/overrun reporting.
module usart_rx_oversampled
  import usart_rx_oversampled_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic              CPU_Clk,
  input  logic              Reset,
  input  logic              RxBit,
  input  logic              Par,
  input  logic              RD,
  output logic [DATA_W-1:0] RxData,
  output logic              AV,
  output logic              FE,
  output logic              PE,
  output logic              OV,
  output logic              Busy
);

  localparam int unsigned DIV_W = $clog2(DIV);

  rx_state_e              state;
  rx_state_e              state_next;
  logic [DIV_W-1:0]       div_cnt;
  logic [TICK_W-1:0]      tick_cnt;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [DATA_W-1:0]      shreg;
  logic                   par_bit;
  logic                   par_q;

  logic rx_s;
  logic vote_c;
  logic voted;

  logic tick_c;
  logic at_t0_c;
  logic at_t1_c;
  logic at_t2_c;
  logic at_dec_c;
  logic sample_en_c;
  logic vote_en_c;
  logic start_ok_c;
  logic shift_c;
  logic par_load_c;
  logic complete_c;
  logic pe_new_c;

  usart_rx_oversampled_rx_sampler u_rx_sampler (
    .CPU_Clk   (CPU_Clk),
    .Reset     (Reset),
    .RxBit     (RxBit),
    .sample_en (sample_en_c),
    .vote_en   (vote_en_c),
    .rx_s      (rx_s),
    .vote_c    (vote_c),
    .voted     (voted)
  );

  // Oversample tick and named tick positions within the current bit
  always_comb begin
    tick_c   = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));
    at_t0_c  = tick_c && (tick_cnt == TICK_W'(SAMPLE_T0));
    at_t1_c  = tick_c && (tick_cnt == TICK_W'(SAMPLE_T1));
    at_t2_c  = tick_c && (tick_cnt == TICK_W'(SAMPLE_T2));
    at_dec_c = tick_c && (tick_cnt == TICK_W'(DECIDE_T));
  end

  // Divider and tick counter; held at zero while idle so START begins aligned
  always_ff @(posedge CPU_Clk) begin
    if (Reset || (state == IDLE)) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick_c) begin
      div_cnt  <= '0;
      tick_cnt <= tick_cnt + TICK_W'(1);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (at_t2_c && vote_c) state_next = IDLE;
        else if (at_dec_c)     state_next = DATA;
      end
      DATA: begin
        if (at_dec_c && (bit_idx == BIT_IDX_W'(DATA_W - 1)))
          state_next = par_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_dec_c) state_next = STOP;
      end
      STOP: begin
        if (at_t2_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    sample_en_c = at_t0_c | at_t1_c;
    vote_en_c   = at_t2_c;
    start_ok_c  = 1'b0;
    shift_c     = 1'b0;
    par_load_c  = 1'b0;
    complete_c  = 1'b0;
    case (state)
      START:   start_ok_c = at_t2_c & ~vote_c;
      DATA:    shift_c    = at_dec_c;
      PARITY:  par_load_c = at_dec_c;
      STOP:    complete_c = at_t2_c;
      default: ;
    endcase
  end

  // Frame datapath: parity mode latch, bit index, shift register, parity bit
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      par_q   <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (start_ok_c) begin
        par_q   <= Par;
        bit_idx <= '0;
      end
      if (shift_c) begin
        shreg[bit_idx] <= voted;
        bit_idx        <= bit_idx + BIT_IDX_W'(1);
      end
      if (par_load_c) begin
        par_bit <= voted;
      end
    end
  end

  always_comb begin
    pe_new_c = par_q & even_parity_checker({shreg, par_bit});
  end

  // CPU-side holding registers with read handshake and overrun detection
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      RxData <= '0;
      AV     <= 1'b0;
      FE     <= 1'b0;
      PE     <= 1'b0;
      OV     <= 1'b0;
    end else if (complete_c && AV && !RD) begin
      OV <= 1'b1;
    end else if (complete_c) begin
      RxData <= shreg;
      FE     <= ~vote_c;
      PE     <= pe_new_c;
      AV     <= 1'b1;
      OV     <= 1'b0;
    end else if (RD && AV) begin
      AV <= 1'b0;
      FE <= 1'b0;
      PE <= 1'b0;
      OV <= 1'b0;
    end
  end

  // Busy follows the state the FSM is entering
  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      Busy <= 1'b0;
    end else begin
      Busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_usart_rx_oversampled.sv
// Directed bench for usart_rx_oversampled with a scoreboard of expected held bytes.
module tb_usart_rx_oversampled;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
  // Cycles from driving the start edge to the edge sampling the completion cycle (no parity)
  localparam int DONE_NOPAR = 618;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  logic       CPU_Clk;
  logic       Reset;
  logic       RxBit;
  logic       Par;
  logic       RD;
  logic [7:0] RxData;
  logic       AV;
  logic       FE;
  logic       PE;
  logic       OV;
  logic       Busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  usart_rx_oversampled #(.DIV(DIV)) dut (
    .CPU_Clk (CPU_Clk),
    .Reset   (Reset),
    .RxBit   (RxBit),
    .Par     (Par),
    .RD      (RD),
    .RxData  (RxData),
    .AV      (AV),
    .FE      (FE),
    .PE      (PE),
    .OV      (OV),
    .Busy    (Busy)
  );

  initial CPU_Clk = 1'b0;
  always #5 CPU_Clk = ~CPU_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic fe, input logic pe, input logic ov);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    e.ov   = ov;
    sb.push_back(e);
  endtask

  // Drive one frame starting just after a rising edge; ends just after a rising edge
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_v,
                            input logic stop_v);
    RxBit = 1'b0;
    repeat (BIT) @(posedge CPU_Clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RxBit = d[i];
      repeat (BIT) @(posedge CPU_Clk);
      #1;
    end
    if (par_en) begin
      RxBit = par_v;
      repeat (BIT) @(posedge CPU_Clk);
      #1;
    end
    RxBit = stop_v;
    repeat (BIT) @(posedge CPU_Clk);
    #1;
    RxBit = 1'b1;
  endtask

  task automatic rd_pulse();
    RD = 1'b1;
    @(posedge CPU_Clk);
    #1;
    RD = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CPU_Clk);
    #1;
  endtask

  // Wait (bounded) for a held byte and compare it against the oldest expectation
  task automatic check_held(input string tag);
    exp_t e;
    int   waited;
    waited = 0;
    while ((AV !== 1'b1) && (waited < 2000)) begin
      @(posedge CPU_Clk);
      #1;
      waited++;
    end
    chk({tag, "_av"}, 32'(AV), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(RxData), 32'(e.data));
      chk({tag, "_fe"},   32'(FE),     32'(e.fe));
      chk({tag, "_pe"},   32'(PE),     32'(e.pe));
      chk({tag, "_ov"},   32'(OV),     32'(e.ov));
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       busy_seen;
    logic       av_seen;

    Reset = 1'b1;
    RxBit = 1'b1;
    Par   = 1'b0;
    RD    = 1'b0;
    repeat (3) @(posedge CPU_Clk);
    #1 Reset = 1'b0;
    idle(4);

    // Reset state
    chk("rst_rxdata", 32'(RxData), 32'h00);
    chk("rst_av",     32'(AV),     32'd0);
    chk("rst_fe",     32'(FE),     32'd0);
    chk("rst_pe",     32'(PE),     32'd0);
    chk("rst_ov",     32'(OV),     32'd0);
    chk("rst_busy",   32'(Busy),   32'd0);

    // Plain frame, no parity
    expect_rx(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check_held("a5");
    chk("a5_busy_idle", 32'(Busy), 32'd0);
    rd_pulse();
    chk("a5_rd_av",   32'(AV),     32'd0);
    chk("a5_rd_hold", 32'(RxData), 32'hA5);

    // Even parity, correct parity bit
    Par = 1'b1;
    expect_rx(8'h07, 1'b0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    check_held("par_ok");
    rd_pulse();

    // Even parity, wrong parity bit
    expect_rx(8'h07, 1'b0, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    check_held("par_bad");
    rd_pulse();
    chk("par_bad_rd_pe", 32'(PE), 32'd0);
    Par = 1'b0;

    // Framing error: stop bit low
    expect_rx(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_held("fe");
    rd_pulse();
    chk("fe_rd_fe", 32'(FE), 32'd0);
    idle(100);

    // 12-cycle low glitch on idle line: must be rejected before tick 10
    busy_seen = 1'b0;
    av_seen   = 1'b0;
    RxBit = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge CPU_Clk);
      #1;
      if (i == 12) RxBit = 1'b1;
      busy_seen = busy_seen | Busy;
      av_seen   = av_seen | AV;
    end
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_av",        32'(av_seen),   32'd0);
    chk("glitch_idle",      32'(Busy),      32'd0);
    idle(50);

    // Back-to-back frames without read: overrun keeps the first byte
    expect_rx(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    check_held("ov_first");
    expect_rx(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    check_held("ov_second");

    // Third frame with RD on its completion cycle: new byte loads, OV clears
    expect_rx(8'h33, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h33, 1'b0, 1'b0, 1'b1);
      begin
        repeat (DONE_NOPAR) @(posedge CPU_Clk);
        #1 RD = 1'b1;
        @(posedge CPU_Clk);
        #1 RD = 1'b0;
      end
    join
    check_held("ov_rd_same");
    rd_pulse();
    chk("ov_rd_av", 32'(AV), 32'd0);

    // Reset during data bit 4 of 8'h5A
    d = 8'h5A;
    RxBit = 1'b0;
    idle(BIT - 1);
    for (int i = 0; i < 4; i++) begin
      RxBit = d[i];
      idle(BIT - 1);
    end
    RxBit = d[4];
    idle(BIT / 2);
    chk("abort_busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(posedge CPU_Clk);
    #1 Reset = 1'b0;
    chk("abort_busy",   32'(Busy),   32'd0);
    chk("abort_rxdata", 32'(RxData), 32'h00);
    RxBit = 1'b1;
    idle(200);
    chk("abort_av", 32'(AV), 32'd0);
    chk("abort_ov", 32'(OV), 32'd0);

    expect_rx(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check_held("after_abort");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
